// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_BITS_C  = 16;
  localparam int unsigned DEF_DIM     = 8;

  function automatic int unsigned feed_len(input int unsigned dim);
    return 3 * dim - 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned dim);
    return $clog2(3 * dim);
  endfunction

  localparam int unsigned FEED_LEN = feed_len(DEF_DIM);
  localparam int unsigned CNT_W    = cnt_w(DEF_DIM);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StRead,
    StDone
  } ctrl_state_t;

  typedef logic signed [DEF_BITS_AB-1:0] op_lane_t;
  typedef logic signed [DEF_BITS_C-1:0]  acc_lane_t;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Operand memory, array control and C-row stream signals of the sequencer.
interface systolic_ctrl_if #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter int unsigned DIM     = 8
);
  localparam int unsigned AddrW = $clog2(DIM);

  logic                            mem_rd_en;
  logic [AddrW-1:0]                mem_addr;
  logic [DIM-1:0][BITS_AB-1:0]     mem_a_data;
  logic [DIM-1:0][BITS_AB-1:0]     mem_b_data;

  logic [DIM-1:0][BITS_AB-1:0]     sa_A;
  logic [DIM-1:0][BITS_AB-1:0]     sa_B;
  logic [DIM-1:0][BITS_C-1:0]      sa_Cin;
  logic                            sa_WrEn;
  logic                            sa_en;
  logic [AddrW-1:0]                sa_Crow;
  logic [DIM-1:0][BITS_C-1:0]      sa_Cout;

  logic                            c_valid;
  logic                            c_ready;
  logic [AddrW-1:0]                c_row;
  logic [DIM-1:0][BITS_C-1:0]      c_data;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_a_data, mem_b_data,
    output sa_A, sa_B, sa_Cin, sa_WrEn, sa_en, sa_Crow,
    input  sa_Cout,
    output c_valid, c_row, c_data,
    input  c_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_a_data, mem_b_data,
    input  sa_A, sa_B, sa_Cin, sa_WrEn, sa_en, sa_Crow,
    output sa_Cout,
    input  c_valid, c_row, c_data,
    output c_ready
  );

endinterface

// File: rtl/skew_delay.sv
// Per-lane skew: lane k is delayed k cycles and forced to zero unless it
// carries a sample that came from a valid memory read.
module skew_delay #(
  parameter int unsigned W   = 8,
  parameter int unsigned DIM = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic                  vld_i,
  input  logic [DIM-1:0][W-1:0] data_i,
  output logic [DIM-1:0][W-1:0] data_o
);

  assign data_o[0] = vld_i ? data_i[0] : '0;

  for (genvar k = 1; k < DIM; k++) begin : g_lane
    logic [k-1:0][W-1:0] dat_q;
    logic [k-1:0]        vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        dat_q <= '0;
        vld_q <= '0;
      end else if (clr_i) begin
        dat_q <= '0;
        vld_q <= '0;
      end else if (adv_i) begin
        dat_q[0] <= vld_i ? data_i[k] : '0;
        vld_q[0] <= vld_i;
        for (int s = 1; s < k; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign data_o[k] = vld_q[k-1] ? dat_q[k-1] : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer running one systolic array through clear, skewed operand feed
// and row-by-row C unload.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned BITS_C  = DEF_BITS_C,
  parameter int unsigned DIM     = DEF_DIM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            accum,
  output logic            busy,
  output logic            done,
  systolic_ctrl_if.master bus
);

  localparam int unsigned FeedLen = feed_len(DIM);
  localparam int unsigned CntW    = cnt_w(DIM);
  localparam int unsigned AddrW   = $clog2(DIM);

  ctrl_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_q;

  logic             rd_en;
  logic [AddrW-1:0] rd_addr;
  logic             wr_en;
  logic             mac_en;
  logic [AddrW-1:0] crow;
  logic             c_valid;
  logic [AddrW-1:0] c_row;
  logic             skew_clr;
  logic             skew_adv;

  logic [DIM-1:0][BITS_AB-1:0] skew_a;
  logic [DIM-1:0][BITS_AB-1:0] skew_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b1;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    mac_en   = 1'b0;
    crow     = '0;
    c_valid  = 1'b0;
    c_row    = '0;
    skew_clr = 1'b0;
    skew_adv = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          cnt_d = '0;
          if (accum) begin
            state_d  = StFeed;
            skew_clr = 1'b1;
          end else begin
            state_d = StClear;
          end
        end
      end

      StClear: begin
        wr_en = 1'b1;
        crow  = cnt_q[AddrW-1:0];
        if (cnt_q == CntW'(DIM - 1)) begin
          cnt_d    = '0;
          state_d  = StFeed;
          skew_clr = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StFeed: begin
        skew_adv = 1'b1;
        if (cnt_q < CntW'(DIM)) begin
          rd_en   = 1'b1;
          rd_addr = cnt_q[AddrW-1:0];
        end
        // First cycle only issues the read; data reaches lane 0 one cycle later.
        mac_en = (cnt_q != '0);
        if (cnt_q == CntW'(FeedLen - 1)) begin
          cnt_d   = '0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRead: begin
        c_valid = 1'b1;
        c_row   = cnt_q[AddrW-1:0];
        crow    = cnt_q[AddrW-1:0];
        if (bus.c_ready) begin
          if (cnt_q == CntW'(DIM - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  skew_delay #(
    .W   (BITS_AB),
    .DIM (DIM)
  ) u_skew_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (skew_clr),
    .adv_i  (skew_adv),
    .vld_i  (rd_q),
    .data_i (bus.mem_a_data),
    .data_o (skew_a)
  );

  skew_delay #(
    .W   (BITS_AB),
    .DIM (DIM)
  ) u_skew_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (skew_clr),
    .adv_i  (skew_adv),
    .vld_i  (rd_q),
    .data_i (bus.mem_b_data),
    .data_o (skew_b)
  );

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_addr;
  assign bus.sa_A      = skew_a;
  assign bus.sa_B      = skew_b;
  assign bus.sa_Cin    = '0;
  assign bus.sa_WrEn   = wr_en;
  assign bus.sa_en     = mac_en;
  assign bus.sa_Crow   = crow;
  assign bus.c_valid   = c_valid;
  assign bus.c_row     = c_row;
  assign bus.c_data    = c_valid ? bus.sa_Cout : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with behavioural operand memory and array.
module tb_systolic_ctrl;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic accum = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.BITS_AB(8), .BITS_C(16), .DIM(N)) bus ();

  systolic_ctrl #(.BITS_AB(8), .BITS_C(16), .DIM(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .accum (accum),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  // Operand memory: one-cycle read latency.
  logic [7:0] mat_a [N][N];
  logic [7:0] mat_b [N][N];
  logic [N-1:0][7:0] mem_a_q, mem_b_q;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      for (int i = 0; i < N; i++) begin
        mem_a_q[i] <= mat_a[i][bus.mem_addr];
        mem_b_q[i] <= mat_b[bus.mem_addr][i];
      end
    end
  end
  assign bus.mem_a_data = mem_a_q;
  assign bus.mem_b_data = mem_b_q;

  // Output-stationary array: A flows right, B flows down.
  int acc [N][N];
  int a_r [N][N];
  int b_r [N][N];

  function automatic int a_in(int i, int j);
    return (j == 0) ? int'($signed(bus.sa_A[i])) : a_r[i][j-1];
  endfunction

  function automatic int b_in(int i, int j);
    return (i == 0) ? int'($signed(bus.sa_B[j])) : b_r[i-1][j];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= 0;
          a_r[i][j] <= 0;
          b_r[i][j] <= 0;
        end
    end else if (bus.sa_WrEn) begin
      for (int j = 0; j < N; j++) acc[bus.sa_Crow][j] <= int'($signed(bus.sa_Cin[j]));
    end else if (bus.sa_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
          a_r[i][j] <= a_in(i, j);
          b_r[i][j] <= b_in(i, j);
        end
    end
  end

  logic [N-1:0][15:0] cout_m;
  always_comb begin
    cout_m = '0;
    for (int j = 0; j < N; j++) cout_m[j] = acc[bus.sa_Crow][j][15:0];
  end
  assign bus.sa_Cout = cout_m;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int exp_c [N][N];
  logic [127:0] exp_q [$];
  logic [63:0] snap3, snap11;

  task automatic load_ident_b();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = (i == j) ? 8'd1 : 8'd0;
        mat_b[i][j] = 8'(i * N + j);
      end
  endtask

  task automatic run(input logic acc_i, input bit slow_ready, input bit inject,
                     input bit skew_mode);
    int cyc = 0;
    int acc_row = 0;
    int ph = 0;
    int last_acc = -100;
    int done_at = -1;
    int wr_cnt = 0;
    int en_cnt = 0;
    int rd_cyc = 0;
    int done_cnt = 0;
    int overlap = 0;
    logic first_rd, first_wr;
    logic [127:0] row;

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'($signed(mat_a[i][k])) * int'($signed(mat_b[k][j]));
        exp_c[i][j] = (acc_i ? exp_c[i][j] : 0) + s;
        row[j*16 +: 16] = exp_c[i][j][15:0];
      end
      exp_q.push_back(row);
    end

    @(negedge clk);
    start = 1'b1;
    accum = acc_i;
    @(negedge clk);
    start = 1'b0;
    first_rd = bus.mem_rd_en;
    first_wr = bus.sa_WrEn;

    while (done_at < 0 && cyc < 300) begin
      start = 1'b0;
      if (bus.sa_WrEn) wr_cnt++;
      if (bus.sa_en && bus.sa_WrEn) overlap++;
      if (bus.sa_en) begin
        if (skew_mode && en_cnt == 3) snap3 = bus.sa_A;
        if (skew_mode && en_cnt == 11) snap11 = bus.sa_A;
        en_cnt++;
        if (inject && en_cnt == 6) start = 1'b1;
      end
      if (bus.c_valid) begin
        rd_cyc++;
        if (inject && rd_cyc == 3) start = 1'b1;
        bus.c_ready = slow_ready ? (ph == 2) : 1'b1;
        ph = (ph + 1) % 3;
        check("c_row", bus.c_row, acc_row);
        if (exp_q.size() == 0) check("c_extra_row", 1, 0);
        else check("c_data", bus.c_data, exp_q[0]);
        if (bus.c_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (acc_row == N - 1) last_acc = cyc;
          acc_row++;
        end
      end else begin
        bus.c_ready = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
        if (inject) start = 1'b1;  // coincides with the DONE cycle
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    check("timeout", (done_at < 0), 0);
    check("first_rd", first_rd, acc_i);
    check("first_wr", first_wr, !acc_i);
    check("wr_cycles", wr_cnt, acc_i ? 0 : N);
    check("en_cycles", en_cnt, 3 * N - 2);
    check("en_wr_overlap", overlap, 0);
    check("read_cycles", rd_cyc, slow_ready ? 3 * N : N);
    check("rows_left", exp_q.size(), 0);
    check("done_latency", done_at - last_acc, 1);
    if (skew_mode) begin
      check("skew_e3", snap3, 64'h0000_0000_0101_0101);
      check("skew_e11", snap11, 64'h0101_0101_0000_0000);
    end
    for (int c = 0; c < 3; c++) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_count", done_cnt, 1);
    exp_q.delete();
  endtask

  initial begin
    int n_en;
    bus.c_ready = 1'b0;
    snap3 = '0;
    snap11 = '0;
    load_ident_b();

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_wren", bus.sa_WrEn, 0);
    check("rst_en", bus.sa_en, 0);
    check("rst_cvalid", bus.c_valid, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_crow", bus.sa_Crow, 0);
    check("rst_c_row", bus.c_row, 0);
    check("rst_sa_a", bus.sa_A, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // C = A x B with identity A, plus ignored starts in FEED, READ and DONE.
    run(1'b0, 1'b0, 1'b1, 1'b0);

    // C += A x B with slow consumer.
    run(1'b1, 1'b1, 1'b0, 1'b0);

    // Skew shape with all-ones A.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'd1;
        mat_b[i][j] = 8'd0;
      end
    run(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort in the middle of FEED, then a full run.
    load_ident_b();
    @(negedge clk);
    start = 1'b1;
    accum = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_en = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.sa_en) n_en++;
      if (n_en == 10) break;
      @(negedge clk);
    end
    check("pre_abort_en", bus.sa_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_en", bus.sa_en, 0);
    check("abort_rd_en", bus.mem_rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_cvalid", bus.c_valid, 0);
    check("abort_sa_a", bus.sa_A, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
